// File: rtl/char_uart_tx.sv
// Byte FIFO feeding a UART transmitter: 8N1 by default, 8E1 when the
// CHAR_UART_TX_PARITY_EN macro is defined (even parity bit after the data bits).
module char_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [7:0]                  i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef CHAR_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, overflow_q;
    logic          push, pop, bit_done;
    logic [7:0]    head_byte;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          tx_q, busy_q;
`ifdef CHAR_UART_TX_PARITY_EN
    logic          parity_q;
`endif

    // Pops happen only from IDLE or on the last cycle of STOP, never when empty.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        bit_done  = (timer_q == BIT_LAST);
        head_byte = mem_q[rd_ptr_q];
        push      = i_valid && ready_q;
        pop       = (count_q != '0) &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_done));
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
            if (i_valid && !ready_q) overflow_q <= 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers and count decide which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef CHAR_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            timer_q <= bit_done ? '0 : timer_q + TW'(1);
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (pop) begin
                        shift_q  <= head_byte;
`ifdef CHAR_UART_TX_PARITY_EN
                        parity_q <= ^head_byte;
`endif
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt_q == 3'd7) begin
`ifdef CHAR_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
`ifdef CHAR_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift_q  <= head_byte;
`ifdef CHAR_UART_TX_PARITY_EN
                            parity_q <= ^head_byte;
`endif
                            state_q  <= START;
                            tx_q     <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready      = ready_q;
    assign o_tx         = tx_q;
    assign o_busy       = busy_q;
    assign o_fifo_count = count_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_char_uart_tx.sv
// Self-checking bench for char_uart_tx: a queue-based line model checked every
// cycle, plus hand-computed frame, latency, fill and reset expectations.
module tb_char_uart_tx;
    localparam int CLKS  = 4;
    localparam int DEPTH = 16;
`ifdef CHAR_UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [10:0] FRAME_48 = 11'b10010010000;
    localparam logic [10:0] FRAME_45 = 11'b11010001010;
`else
    localparam int NBITS = 10;
    localparam logic [10:0] FRAME_48 = 11'b01010010000;
    localparam logic [10:0] FRAME_45 = 11'b01010001010;
`endif
    localparam int FRAME_CYC = NBITS * CLKS;

    logic       clk;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic [4:0] o_fifo_count;
    logic       o_overflow;

    int checks = 0;
    int errors = 0;

    char_uart_tx #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_fifo_count (o_fifo_count),
        .o_overflow   (o_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // Line model: queue of bytes waiting, queue of per-cycle line levels still to send.
    logic [7:0] m_fifo[$];
    bit         m_line[$];
    bit         m_ovf   = 1'b0;
    bit         m_ready = 1'b1;

    task automatic m_load(input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(b[j]);
`ifdef CHAR_UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[j]) begin
            repeat (CLKS) m_line.push_back(bits[j]);
        end
    endtask

    task automatic m_edge();
        if (!i_rst_n) begin
            m_fifo.delete();
            m_line.delete();
            m_ovf   = 1'b0;
            m_ready = 1'b1;
        end else begin
            if (m_line.size() != 0) m_line.delete(0);
            if (m_line.size() == 0 && m_fifo.size() != 0) m_load(m_fifo.pop_front());
            if (i_valid) begin
                if (m_ready) m_fifo.push_back(i_data);
                else         m_ovf = 1'b1;
            end
            m_ready = (m_fifo.size() != DEPTH);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge i_rst_n);
            m_edge();
        end
    end

    bit cmp_en     = 1'b0;
    bit prev_busy  = 1'b0;
    int busy_total = 0;
    int busy_falls = 0;
    int peak       = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_tx",    o_tx,         (m_line.size() != 0) ? m_line[0] : 1'b1);
                check("model_busy",  o_busy,       m_line.size() != 0);
                check("model_count", o_fifo_count, m_fifo.size());
                check("model_ready", o_ready,      m_ready);
                check("model_ovf",   o_overflow,   m_ovf);
                if (o_busy) busy_total++;
                if (prev_busy && !o_busy) busy_falls++;
                prev_busy = o_busy;
                if (int'(o_fifo_count) > peak) peak = int'(o_fifo_count);
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (o_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", o_busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame_check(input logic [7:0] d, input logic [10:0] frame, input string tag);
        int busy_n = 0;
        i_valid = 1'b1;
        i_data  = d;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check({tag, "_pre_start_tx"}, o_tx, 1'b1);
        check({tag, "_pre_start_cnt"}, o_fifo_count, 1);
        @(posedge clk);
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            check({tag, "_bit"}, o_tx, frame[i / CLKS]);
            if (o_busy) busy_n++;
        end
        @(negedge clk);
        check({tag, "_busy_len"}, busy_n, FRAME_CYC);
        check({tag, "_idle_after"}, o_busy, 1'b0);
        check({tag, "_tx_after"}, o_tx, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        string s;
        int    tot0, falls0, lows;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("reset_tx",    o_tx,         1'b1);
        check("reset_busy",  o_busy,       1'b0);
        check("reset_count", o_fifo_count, 0);
        check("reset_ready", o_ready,      1'b1);
        check("reset_ovf",   o_overflow,   1'b0);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // Single frames with hand-derived line patterns.
        send_frame_check(8'h48, FRAME_48, "frame48");
        send_frame_check(8'h45, FRAME_45, "frame45");

        // Six back-to-back characters.
        s      = "HERASH";
        tot0   = busy_total;
        falls0 = busy_falls;
        peak   = 0;
        for (int i = 0; i < 6; i++) begin
            i_valid = 1'b1;
            i_data  = s[i];
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        wait_idle(600);
        check("herash_busy_cycles", busy_total - tot0, 6 * FRAME_CYC);
        check("herash_no_gap",      busy_falls - falls0, 1);
        check("herash_peak",        peak, 5);
        check("herash_ovf",         o_overflow, 1'b0);

        // Eighteen consecutive bytes: one popped, sixteen fill the FIFO, last dropped.
        tot0   = busy_total;
        falls0 = busy_falls;
        for (int i = 1; i <= 18; i++) begin
            i_valid = 1'b1;
            i_data  = 8'(8'h60 + i);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        @(negedge clk);
        check("fill_count", o_fifo_count, 16);
        check("fill_ready", o_ready,      1'b0);
        check("fill_ovf",   o_overflow,   1'b1);
        wait_idle(17 * FRAME_CYC + 100);
        check("fill_busy_cycles", busy_total - tot0, 17 * FRAME_CYC);
        check("fill_no_gap",      busy_falls - falls0, 1);
        check("fill_ovf_sticky",  o_overflow, 1'b1);

        // Reset during data bit 3 of 0x45 (bit value 0).
        i_valid = 1'b1;
        i_data  = 8'h45;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(posedge clk);
        repeat (17) @(posedge clk);
        #3;
        check("pre_rst_bit3", o_tx,   1'b0);
        check("pre_rst_busy", o_busy, 1'b1);
        i_rst_n = 1'b0;
        #1;
        check("midrst_tx",    o_tx,         1'b1);
        check("midrst_busy",  o_busy,       1'b0);
        check("midrst_count", o_fifo_count, 0);
        check("midrst_ready", o_ready,      1'b1);
        check("midrst_ovf",   o_overflow,   1'b0);
        i_valid = 1'b1;
        i_data  = 8'h55;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_no_write", o_fifo_count, 0);
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b1;
        tot0 = busy_total;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!o_tx) lows++;
        end
        check("post_rst_line_low", lows, 0);
        check("post_rst_busy",     busy_total - tot0, 0);
        @(posedge clk);
        #1;

        send_frame_check(8'h48, FRAME_48, "recover48");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
